dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Parametrised dispatch and recovery controller for the N-wide out-of-order prototype; sits between rename and the reservation stations/ROB. Each cycle it grants an in-order prefix of the rename group against the free-entry counts of the add RS, mul RS, PRF and ROB. It remembers which slots of a stalled group are already dispatched, and sequences flush and recovery after a commit-time exception.

## Interface
- WIDTH, 3, number of dispatch slots per cycle (1..8)
- CNT_W, 5, width of each free-count input
- RECOVER_CYCLES, 2, cycles spent in RECOVER after a flush (>=1)
- PERF_W, 16, width of the stall counter
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high, sampled on the rising edge of clk
- valid_in  in  WIDTH  slot i holds an instruction from rename
- is_mul  in  WIDTH  slot i targets the mul RS (else the add RS)
- need_prf  in  WIDTH  slot i allocates a physical register
- free_rs_add, free_rs_mul, free_prf, free_rob  in  CNT_W each  free entries available this cycle
- exp_commit  in  1  exception at ROB head this cycle
- valid_issue  out  WIDTH  slot i dispatched this cycle
- dispatch_cnt  out  $clog2(WIDTH+1)  popcount(valid_issue)
- freeze_front  out  1  hold fetch/decode/rename registers
- freeze_back  out  1  hold RS issue and execute
- flush  out  1  kill all in-flight work and restore rename state
- perf_stall  out  PERF_W  saturating count of resource-stall cycles

## Operation
- State: RUN, FLUSH, RECOVER. Registers: state, done_mask[WIDTH], rec_cnt, perf_stall.
- Pending slots: pend = valid_in & ~done_mask.
- Grant (RUN, exp_commit=0):
  - Walk slots 0..WIDTH-1 in order, accumulating demand.
  - Pending slot i adds 1 to ROB demand, 1 to add-RS or mul-RS demand per is_mul[i], and need_prf[i] to PRF demand.
  - Slot i is granted iff every pending slot j<i is granted and all four cumulative demands, including slot i, are <= their free counts.
  - Non-pending slots consume nothing and never block.
  - First failing slot blocks all later slots (strict in-order).
- Partial group: resource_stall = |(pend & ~grant).
  - freeze_front = resource_stall.
  - done_mask <= done_mask | grant while resource_stall=1.
  - done_mask <= 0 once the group completes (resource_stall=0).
  - The front end holds the group; already-dispatched slots are never granted twice.
- Exception:
  - exp_commit=1 in RUN: valid_issue=0 and freeze_front=1 that cycle; next state FLUSH; done_mask <= 0.
  - exp_commit=1 on the same cycle as a partial grant: exception wins, nothing is granted.
- FLUSH (1 cycle): flush=1, freeze_front=1, freeze_back=1, valid_issue=0; rec_cnt <= RECOVER_CYCLES-1; next RECOVER.
- RECOVER: freeze_front=1, freeze_back=1, valid_issue=0, flush=0; rec_cnt decrements; at rec_cnt=0 next RUN.
- exp_commit is ignored in FLUSH and RECOVER.
- perf_stall increments on each RUN cycle with resource_stall=1 and exp_commit=0; it saturates at all-ones and clears only on rst.
- Free counts above WIDTH are legal; arithmetic is unsigned at CNT_W+1 bits, with no wrap.

## Timing
- Combinational from inputs and current state, zero latency: valid_issue, dispatch_cnt, freeze_front.
- Registered, decoded from state: flush and freeze_back. flush is high exactly one cycle, the cycle after exp_commit is sampled.
- Exception to first possible dispatch: 2 + RECOVER_CYCLES cycles.
- Reset values:
  - Registers: state=RUN, done_mask=0, rec_cnt=0, perf_stall=0.
  - Outputs: flush=0, freeze_back=0; valid_issue, dispatch_cnt and freeze_front follow the inputs under RUN with done_mask=0.
- rst mid-FLUSH or mid-RECOVER returns to RUN on the next edge with no flush pulse; rst overrides exp_commit.
- Free counts are consumed in the cycle of grant; upstream structures must reflect allocations by the next cycle.

## Test plan
- WIDTH=3, all valid, all add, need_prf=111, free counts all 8 -> valid_issue=111, dispatch_cnt=3, freeze_front=0, done_mask stays 0.
- Partial group: valid=111, is_mul=000, free_rs_add=1, then 8 on the next cycle -> cycle 0: valid_issue=001, freeze_front=1; cycle 1: valid_issue=110, freeze_front=0, done_mask returns to 0.
- In-order block: valid=111, is_mul=001, free_rs_mul=0, free_rs_add=8 -> valid_issue=000 (slot 0 blocks slots 1 and 2), perf_stall increments by 1.
- Bubble: valid=101, free_rob=2 -> valid_issue=101, dispatch_cnt=2; with free_rob=1 -> valid_issue=001, freeze_front=1.
- Exception: exp_commit pulsed at cycle t with RECOVER_CYCLES=2 -> valid_issue=0 at t; flush=1 only at t+1; freeze_back=1 at t+1..t+3; RUN and dispatch resume at t+4. A second exp_commit at t+2 has no effect.
- Reset during RECOVER, and perf_stall held at all-ones under a continuous stall -> state returns to RUN with flush never asserted; perf_stall does not wrap.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: grants an in-order prefix of the rename group against the
// free-entry counts of the add RS, mul RS, PRF and ROB, remembers which slots
// of a stalled group have already gone out, and sequences the flush/recovery
// window after a commit-time exception.
module dispatch_ctrl #(
  parameter int WIDTH          = 3,
  parameter int CNT_W          = 5,
  parameter int RECOVER_CYCLES = 2,
  parameter int PERF_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           valid_in,
  input  logic [WIDTH-1:0]           is_mul,
  input  logic [WIDTH-1:0]           need_prf,
  input  logic [CNT_W-1:0]           free_rs_add,
  input  logic [CNT_W-1:0]           free_rs_mul,
  input  logic [CNT_W-1:0]           free_prf,
  input  logic [CNT_W-1:0]           free_rob,
  input  logic                       exp_commit,
  output logic [WIDTH-1:0]           valid_issue,
  output logic [$clog2(WIDTH+1)-1:0] dispatch_cnt,
  output logic                       freeze_front,
  output logic                       freeze_back,
  output logic                       flush,
  output logic [PERF_W-1:0]          perf_stall
);

  // Demand accumulators are one bit wider than the free counts so the
  // comparison never wraps, even when every slot asks for the same resource.
  localparam int DW    = CNT_W + 1;
  localparam int DCW   = $clog2(WIDTH + 1);
  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   done_mask, done_nxt;
  logic [REC_W-1:0]   rec_cnt, rec_nxt;
  logic [WIDTH-1:0]   pend;
  logic [WIDTH-1:0]   grant;
  logic               resource_stall;
  logic               perf_inc;

  assign pend           = valid_in & ~done_mask;
  assign resource_stall = |(pend & ~grant);

  // In-order grant walk: each pending slot adds its demand, the first slot
  // that overruns any free count blocks itself and every slot after it.
  always_comb begin
    logic [DW-1:0] dem_add, dem_mul, dem_prf, dem_rob;
    logic [DW-1:0] nxt_add, nxt_mul, nxt_prf, nxt_rob;
    logic          blocked;
    dem_add = '0;
    dem_mul = '0;
    dem_prf = '0;
    dem_rob = '0;
    nxt_add = '0;
    nxt_mul = '0;
    nxt_prf = '0;
    nxt_rob = '0;
    blocked = 1'b0;
    grant   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend[i] && !blocked) begin
        nxt_add = dem_add + DW'(!is_mul[i]);
        nxt_mul = dem_mul + DW'(is_mul[i]);
        nxt_prf = dem_prf + DW'(need_prf[i]);
        nxt_rob = dem_rob + DW'(1);
        if ((nxt_add <= {1'b0, free_rs_add}) &&
            (nxt_mul <= {1'b0, free_rs_mul}) &&
            (nxt_prf <= {1'b0, free_prf}) &&
            (nxt_rob <= {1'b0, free_rob})) begin
          grant[i] = 1'b1;
          dem_add  = nxt_add;
          dem_mul  = nxt_mul;
          dem_prf  = nxt_prf;
          dem_rob  = nxt_rob;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // Next-state, slot bookkeeping and the combinational dispatch outputs;
  // an exception at the ROB head overrides any grant in the same cycle.
  always_comb begin
    state_nxt    = state;
    done_nxt     = done_mask;
    rec_nxt      = rec_cnt;
    valid_issue  = '0;
    freeze_front = 1'b0;
    perf_inc     = 1'b0;
    case (state)
      ST_RUN: begin
        if (exp_commit) begin
          freeze_front = 1'b1;
          done_nxt     = '0;
          state_nxt    = ST_FLUSH;
        end else begin
          valid_issue  = grant;
          freeze_front = resource_stall;
          done_nxt     = resource_stall ? (done_mask | grant) : '0;
          perf_inc     = resource_stall;
        end
      end
      ST_FLUSH: begin
        freeze_front = 1'b1;
        done_nxt     = '0;
        rec_nxt      = REC_W'(RECOVER_CYCLES - 1);
        state_nxt    = ST_RECOVER;
      end
      ST_RECOVER: begin
        freeze_front = 1'b1;
        done_nxt     = '0;
        if (rec_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          rec_nxt = rec_cnt - REC_W'(1);
        end
      end
      default: begin
        done_nxt  = '0;
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Number of slots that actually left this cycle.
  always_comb begin
    dispatch_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dispatch_cnt = dispatch_cnt + DCW'(valid_issue[i]);
    end
  end

  // Back-end freeze and the flush pulse come straight from the state register.
  assign flush       = (state == ST_FLUSH);
  assign freeze_back = (state != ST_RUN);

  // State, done mask and recovery counter; reset drops straight into RUN so a
  // reset mid-recovery never produces a flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      done_mask <= '0;
      rec_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      done_mask <= done_nxt;
      rec_cnt   <= rec_nxt;
    end
  end

  // Saturating resource-stall counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
    end else if (perf_inc && (perf_stall != {PERF_W{1'b1}})) begin
      perf_stall <= perf_stall + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a table of single-cycle vectors walked in
// order, then hand-written exception, reset and saturation sequences.
module tb_dispatch_ctrl;

  localparam int WIDTH = 3;
  localparam int CNT_W = 5;
  localparam int RECC  = 2;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] valid_in, is_mul, need_prf;
  logic [CNT_W-1:0] free_rs_add, free_rs_mul, free_prf, free_rob;
  logic             exp_commit;
  logic [WIDTH-1:0] valid_issue;
  logic [1:0]       dispatch_cnt;
  logic             freeze_front, freeze_back, flush;
  logic [PW-1:0]    perf_stall;

  int checks = 0;
  int errors = 0;

  dispatch_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .RECOVER_CYCLES(RECC), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .is_mul(is_mul), .need_prf(need_prf),
    .free_rs_add(free_rs_add), .free_rs_mul(free_rs_mul),
    .free_prf(free_prf), .free_rob(free_rob),
    .exp_commit(exp_commit),
    .valid_issue(valid_issue), .dispatch_cnt(dispatch_cnt),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .flush(flush), .perf_stall(perf_stall)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v, m, n;
    logic [4:0] fa, fm, fp, fr;
    logic [2:0] e_issue;
    logic [1:0] e_cnt;
    logic       e_ff;
    logic [3:0] e_perf;
  } vec_t;

  vec_t vecs[16];

  task automatic apply_stimulus(input logic [2:0] v, input logic [2:0] m,
                                input logic [2:0] n, input logic [4:0] fa,
                                input logic [4:0] fm, input logic [4:0] fp,
                                input logic [4:0] fr, input logic ex);
    valid_in    = v;
    is_mul      = m;
    need_prf    = n;
    free_rs_add = fa;
    free_rs_mul = fm;
    free_prf    = fp;
    free_rob    = fr;
    exp_commit  = ex;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dispatch(input string tag, input logic [2:0] ei,
                                input logic [1:0] ec, input logic ef);
    check_output({tag, " valid_issue"}, 32'(valid_issue), 32'(ei));
    check_output({tag, " dispatch_cnt"}, 32'(dispatch_cnt), 32'(ec));
    check_output({tag, " freeze_front"}, 32'(freeze_front), 32'(ef));
  endtask

  task automatic check_back(input string tag, input logic ef, input logic eb);
    check_output({tag, " flush"}, 32'(flush), 32'(ef));
    check_output({tag, " freeze_back"}, 32'(freeze_back), 32'(eb));
  endtask

  initial begin
    // Sequential vectors; expectations account for the done mask and
    // stall count carried over from the previous row.
    //          v       m       n       fa     fm     fp     fr     issue   cnt ff perf
    vecs[0]  = '{3'b111, 3'b000, 3'b111, 5'd8,  5'd8,  5'd8,  5'd8,  3'b111, 2'd3, 1'b0, 4'd0};
    vecs[1]  = '{3'b111, 3'b000, 3'b111, 5'd1,  5'd8,  5'd8,  5'd8,  3'b001, 2'd1, 1'b1, 4'd0};
    vecs[2]  = '{3'b111, 3'b000, 3'b111, 5'd8,  5'd8,  5'd8,  5'd8,  3'b110, 2'd2, 1'b0, 4'd1};
    vecs[3]  = '{3'b111, 3'b001, 3'b111, 5'd8,  5'd0,  5'd8,  5'd8,  3'b000, 2'd0, 1'b1, 4'd1};
    vecs[4]  = '{3'b101, 3'b000, 3'b000, 5'd8,  5'd8,  5'd8,  5'd2,  3'b101, 2'd2, 1'b0, 4'd2};
    vecs[5]  = '{3'b101, 3'b000, 3'b000, 5'd8,  5'd8,  5'd8,  5'd1,  3'b001, 2'd1, 1'b1, 4'd2};
    vecs[6]  = '{3'b101, 3'b000, 3'b000, 5'd8,  5'd8,  5'd8,  5'd1,  3'b100, 2'd1, 1'b0, 4'd3};
    vecs[7]  = '{3'b111, 3'b010, 3'b101, 5'd8,  5'd8,  5'd1,  5'd8,  3'b011, 2'd2, 1'b1, 4'd3};
    vecs[8]  = '{3'b111, 3'b010, 3'b101, 5'd8,  5'd8,  5'd0,  5'd8,  3'b000, 2'd0, 1'b1, 4'd4};
    vecs[9]  = '{3'b111, 3'b010, 3'b101, 5'd8,  5'd8,  5'd1,  5'd8,  3'b100, 2'd1, 1'b0, 4'd5};
    vecs[10] = '{3'b000, 3'b000, 3'b000, 5'd0,  5'd0,  5'd0,  5'd0,  3'b000, 2'd0, 1'b0, 4'd5};
    vecs[11] = '{3'b111, 3'b111, 3'b000, 5'd0,  5'd2,  5'd0,  5'd8,  3'b011, 2'd2, 1'b1, 4'd5};
    vecs[12] = '{3'b111, 3'b111, 3'b000, 5'd0,  5'd1,  5'd0,  5'd8,  3'b100, 2'd1, 1'b0, 4'd6};
    vecs[13] = '{3'b111, 3'b000, 3'b111, 5'd31, 5'd31, 5'd31, 5'd31, 3'b111, 2'd3, 1'b0, 4'd6};
    vecs[14] = '{3'b010, 3'b000, 3'b000, 5'd8,  5'd8,  5'd8,  5'd0,  3'b000, 2'd0, 1'b1, 4'd6};
    vecs[15] = '{3'b010, 3'b000, 3'b000, 5'd8,  5'd8,  5'd8,  5'd1,  3'b010, 2'd1, 1'b0, 4'd7};

    // Reset state
    rst = 1'b1;
    apply_stimulus(3'b111, 3'b000, 3'b111, 5'd8, 5'd8, 5'd8, 5'd8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_back("reset", 1'b0, 1'b0);
    check_output("reset perf_stall", 32'(perf_stall), 32'd0);
    check_dispatch("reset", 3'b111, 2'd3, 1'b0);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].v, vecs[i].m, vecs[i].n, vecs[i].fa,
                     vecs[i].fm, vecs[i].fp, vecs[i].fr, 1'b0);
      #1;
      check_dispatch($sformatf("vec%0d", i), vecs[i].e_issue, vecs[i].e_cnt, vecs[i].e_ff);
      check_output($sformatf("vec%0d perf_stall", i), 32'(perf_stall), 32'(vecs[i].e_perf));
      check_back($sformatf("vec%0d", i), 1'b0, 1'b0);
      @(negedge clk);
    end

    // Exception on a partial-grant cycle, then a second ignored exception
    apply_stimulus(3'b111, 3'b000, 3'b111, 5'd1, 5'd8, 5'd8, 5'd8, 1'b1);
    #1;
    check_dispatch("exc t", 3'b000, 2'd0, 1'b1);
    check_back("exc t", 1'b0, 1'b0);
    @(negedge clk);
    apply_stimulus(3'b111, 3'b000, 3'b111, 5'd8, 5'd8, 5'd8, 5'd8, 1'b0);
    #1;
    check_dispatch("exc t+1", 3'b000, 2'd0, 1'b1);
    check_back("exc t+1", 1'b1, 1'b1);
    @(negedge clk);
    exp_commit = 1'b1;
    #1;
    check_dispatch("exc t+2", 3'b000, 2'd0, 1'b1);
    check_back("exc t+2", 1'b0, 1'b1);
    @(negedge clk);
    exp_commit = 1'b0;
    #1;
    check_dispatch("exc t+3", 3'b000, 2'd0, 1'b1);
    check_back("exc t+3", 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_dispatch("exc t+4", 3'b111, 2'd3, 1'b0);
    check_back("exc t+4", 1'b0, 1'b0);
    check_output("exc perf_stall", 32'(perf_stall), 32'd7);
    @(negedge clk);

    // Reset during RECOVER
    exp_commit = 1'b1;
    @(negedge clk);
    exp_commit = 1'b0;
    #1;
    check_back("rstrec flush", 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_back("rstrec in recover", 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_back("rstrec after", 1'b0, 1'b0);
    check_dispatch("rstrec after", 3'b111, 2'd3, 1'b0);
    check_output("rstrec perf_stall", 32'(perf_stall), 32'd0);
    @(negedge clk);
    #1;
    check_back("rstrec after+1", 1'b0, 1'b0);
    @(negedge clk);

    // Reset during FLUSH
    exp_commit = 1'b1;
    @(negedge clk);
    exp_commit = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_back("rstflush after", 1'b0, 1'b0);
    check_dispatch("rstflush after", 3'b111, 2'd3, 1'b0);
    @(negedge clk);

    // Reset overrides a simultaneous exception
    rst = 1'b1;
    exp_commit = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_commit = 1'b0;
    #1;
    check_back("rst over exp", 1'b0, 1'b0);
    @(negedge clk);

    // Continuous stall: perf_stall climbs and sticks at all-ones
    apply_stimulus(3'b001, 3'b000, 3'b000, 5'd0, 5'd8, 5'd8, 5'd8, 1'b0);
    for (int k = 0; k < 20; k++) begin
      #1;
      check_output($sformatf("sat k=%0d perf_stall", k), 32'(perf_stall),
                   32'((k > 15) ? 15 : k));
      check_dispatch($sformatf("sat k=%0d", k), 3'b000, 2'd0, 1'b1);
      check_output($sformatf("sat k=%0d flush", k), 32'(flush), 32'd0);
      @(negedge clk);
    end
    #1;
    check_output("sat end perf_stall", 32'(perf_stall), 32'd15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("sat cleared perf_stall", 32'(perf_stall), 32'd0);
    check_back("sat cleared", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
